// File: rtl/input_event_unit_if.sv
// Button front-end bus: raw pins and ack in, sticky event flags and debounced levels out.
interface input_event_unit_if #(
  parameter int N_BUTTONS = 5
);
  logic [N_BUTTONS-1:0]   buttons_in;
  logic                   ack;
  logic [2*N_BUTTONS-1:0] control_state;
  logic [N_BUTTONS-1:0]   held;
  logic                   event_pending;

  modport master (
    output buttons_in,
    output ack,
    input  control_state,
    input  held,
    input  event_pending
  );

  modport slave (
    input  buttons_in,
    input  ack,
    output control_state,
    output held,
    output event_pending
  );
endinterface

// File: rtl/input_event_unit.sv
// Synchronise, debounce and edge-detect N buttons into sticky press/release flags (flag 3+D edges after pin change).
// No backpressure: events merge into pending flags until ack; a set in the same cycle as ack survives.
module input_event_unit #(
  parameter int N_BUTTONS       = 5,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8
) (
  input logic               clk,
  input logic               reset,
  input_event_unit_if.slave bus
);
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {R_IDLE, R_DELAY, R_REPEAT} rep_state_e;

  logic [N_BUTTONS-1:0]   s1, s2;
  logic [N_BUTTONS-1:0]   held, held_q;
  logic [N_BUTTONS-1:0]   rise, fall, rep;
  logic [2*N_BUTTONS-1:0] control_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      held_q <= '0;
    end else begin
      s1     <= bus.buttons_in;
      s2     <= s1;
      held_q <= held;
    end
  end

  assign rise = held & ~held_q;
  assign fall = ~held & held_q;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
    logic [CW-1:0] cnt;
    logic          held_r;

    // Flip only after D consecutive cycles of disagreement with the current level.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt    <= '0;
        held_r <= 1'b0;
      end else if (s2[i] == held_r) begin
        cnt    <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        held_r <= s2[i];
        cnt    <= '0;
      end else begin
        cnt    <= cnt + CW'(1);
      end
    end

    assign held[i] = held_r;

    if (REPEAT_DELAY > 0) begin : g_rep
      rep_state_e    state, state_n;
      logic [RW-1:0] rcnt, rcnt_n;
      logic          rep_c;

      always_ff @(posedge clk) begin
        if (reset) begin
          state <= R_IDLE;
          rcnt  <= '0;
        end else begin
          state <= state_n;
          rcnt  <= rcnt_n;
        end
      end

      // Release forces IDLE from any state, so no repeat fires once the level drops.
      always_comb begin
        state_n = state;
        rcnt_n  = rcnt;
        rep_c   = 1'b0;
        if (!held[i]) begin
          state_n = R_IDLE;
          rcnt_n  = '0;
        end else begin
          case (state)
            R_IDLE: begin
              if (rise[i]) begin
                state_n = R_DELAY;
                rcnt_n  = '0;
              end
            end
            R_DELAY: begin
              if (rcnt == RW'(REPEAT_DELAY - 1)) begin
                rep_c   = 1'b1;
                rcnt_n  = '0;
                state_n = R_REPEAT;
              end else begin
                rcnt_n  = rcnt + RW'(1);
              end
            end
            R_REPEAT: begin
              if (rcnt == RW'(REPEAT_PERIOD - 1)) begin
                rep_c  = 1'b1;
                rcnt_n = '0;
              end else begin
                rcnt_n = rcnt + RW'(1);
              end
            end
            default: begin
              state_n = R_IDLE;
              rcnt_n  = '0;
            end
          endcase
        end
      end

      assign rep[i] = rep_c;
    end else begin : g_norep
      assign rep[i] = 1'b0;
    end
  end

  // Set has priority over ack so an event landing on the ack edge is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      control_state <= '0;
    end else begin
      control_state <= (control_state & ~{2*N_BUTTONS{bus.ack}}) | {rise | rep, fall};
    end
  end

  assign bus.control_state = control_state;
  assign bus.held          = held;
  assign bus.event_pending = |control_state;
endmodule

// File: tb/tb_input_event_unit.sv
// Scoreboard bench: expectations are queued with their target edge when stimulus is driven and checked at negedge.
module tb_input_event_unit;
  localparam int N = 5;
  localparam int D = 4;

  localparam int K_CS_A   = 0;
  localparam int K_HELD_A = 1;
  localparam int K_EP_A   = 2;
  localparam int K_CS_B   = 3;
  localparam int K_HELD_B = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  input_event_unit_if #(.N_BUTTONS(N)) ifa ();
  input_event_unit_if #(.N_BUTTONS(N)) ifb ();

  input_event_unit #(
    .N_BUTTONS(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0), .REPEAT_PERIOD(8)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  input_event_unit #(
    .N_BUTTONS(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  typedef struct {
    int          at;
    int          kind;
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h required %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_at(input int at, input int kind, input string tag, input logic [31:0] val);
    exp_t e;
    e.at   = at;
    e.kind = kind;
    e.tag  = tag;
    e.val  = val;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int kind);
    logic [31:0] v;
    v = '0;
    case (kind)
      K_CS_A:   v = 32'(ifa.control_state);
      K_HELD_A: v = 32'(ifa.held);
      K_EP_A:   v = 32'(ifa.event_pending);
      K_CS_B:   v = 32'(ifb.control_state);
      K_HELD_B: v = 32'(ifb.held);
      default:  v = 'x;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        chk(sb[i].tag, observe(sb[i].kind), sb[i].val);
        sb.delete(i);
      end
    end
  end

  // Returns #1 after edge c, so stimulus set here is first sampled by edge c+1.
  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] rep_expect(input int c, input int p);
    logic [31:0] v;
    v = 32'h0;
    if (c == p + 7) v = 32'h020;
    else if (c >= p + 17 && c <= p + 33 && ((c - p - 17) % 4) == 0) v = 32'h020;
    else if (c == p + 35) v = 32'h001;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, g, r, q, a, b, p;
    ifa.buttons_in = '0;
    ifa.ack        = 1'b0;
    ifb.buttons_in = '0;
    ifb.ack        = 1'b1;
    reset          = 1'b1;

    // Press UP while still in reset; edge e0 is the last reset edge.
    e0 = 3;
    wait_to(2);
    ifa.buttons_in[0] = 1'b1;
    expect_at(e0,     K_CS_A,   "rst_cs",        32'h0);
    expect_at(e0,     K_HELD_A, "rst_held",      32'h0);
    expect_at(e0,     K_EP_A,   "rst_pending",   32'h0);
    expect_at(e0,     K_CS_B,   "rst_cs_b",      32'h0);
    expect_at(e0 + 5, K_HELD_A, "t1_held_early", 32'h0);
    expect_at(e0 + 6, K_HELD_A, "t1_held",       32'h01);
    expect_at(e0 + 6, K_CS_A,   "t1_cs_early",   32'h0);
    expect_at(e0 + 7, K_CS_A,   "t1_press",      32'h020);
    expect_at(e0 + 7, K_EP_A,   "t1_pending",    32'h1);
    expect_at(e0 + 8, K_CS_A,   "t1_sticky",     32'h020);
    expect_at(e0 + 9, K_CS_A,   "t1_acked",      32'h0);
    expect_at(e0 + 9, K_EP_A,   "t1_pend_clr",   32'h0);
    expect_at(e0 + 9, K_HELD_A, "t1_held_stays", 32'h01);
    wait_to(e0);
    reset = 1'b0;
    wait_to(e0 + 8);
    ifa.ack = 1'b1;
    wait_to(e0 + 9);
    ifa.ack = 1'b0;

    // Glitch of D-1 cycles on LEFT must never reach held or the flags.
    g = e0 + 12;
    wait_to(g);
    ifa.buttons_in[2] = 1'b1;
    for (int c = g + 1; c <= g + 10; c++) begin
      expect_at(c, K_HELD_A, $sformatf("t2_held_e%0d", c), 32'h01);
      expect_at(c, K_CS_A,   $sformatf("t2_cs_e%0d", c),   32'h0);
    end
    wait_to(g + 3);
    ifa.buttons_in[2] = 1'b0;

    // Release UP.
    r = g + 14;
    wait_to(r);
    ifa.buttons_in[0] = 1'b0;
    expect_at(r + D + 1, K_HELD_A, "t3_held_early", 32'h01);
    expect_at(r + D + 2, K_HELD_A, "t3_held",       32'h0);
    expect_at(r + D + 2, K_CS_A,   "t3_cs_early",   32'h0);
    expect_at(r + D + 3, K_CS_A,   "t3_release",    32'h001);
    expect_at(r + D + 3, K_EP_A,   "t3_pending",    32'h1);
    expect_at(r + D + 5, K_CS_A,   "t3_acked",      32'h0);
    wait_to(r + D + 4);
    ifa.ack = 1'b1;
    wait_to(r + D + 5);
    ifa.ack = 1'b0;

    // DOWN press and release both left pending until one ack.
    q = r + 12;
    wait_to(q);
    ifa.buttons_in[1] = 1'b1;
    expect_at(q + 7,  K_CS_A, "t3b_press",    32'h040);
    expect_at(q + 15, K_CS_A, "t3b_waiting",  32'h040);
    expect_at(q + 16, K_CS_A, "t3b_both",     32'h042);
    expect_at(q + 19, K_CS_A, "t3b_acked",    32'h0);
    wait_to(q + 9);
    ifa.buttons_in[1] = 1'b0;
    wait_to(q + 18);
    ifa.ack = 1'b1;
    wait_to(q + 19);
    ifa.ack = 1'b0;

    // ACTION press flag sets on the same edge that samples ack.
    a = q + 22;
    wait_to(a);
    ifa.buttons_in[4] = 1'b1;
    expect_at(a + 7,  K_CS_A,   "t4_collide",   32'h200);
    expect_at(a + 8,  K_CS_A,   "t4_survives",  32'h200);
    expect_at(a + 9,  K_CS_A,   "t4_second",    32'h0);
    expect_at(a + 11, K_CS_A,   "t4_idle_ack",  32'h0);
    expect_at(a + 11, K_HELD_A, "t4_held",      32'h10);
    expect_at(a + 19, K_CS_A,   "t4_release",   32'h010);
    expect_at(a + 21, K_CS_A,   "t4_rel_acked", 32'h0);
    wait_to(a + 6);
    ifa.ack = 1'b1;
    wait_to(a + 7);
    ifa.ack = 1'b0;
    wait_to(a + 8);
    ifa.ack = 1'b1;
    wait_to(a + 9);
    ifa.ack = 1'b0;
    wait_to(a + 10);
    ifa.ack = 1'b1;
    wait_to(a + 11);
    ifa.ack = 1'b0;
    wait_to(a + 12);
    ifa.buttons_in[4] = 1'b0;
    wait_to(a + 20);
    ifa.ack = 1'b1;
    wait_to(a + 21);
    ifa.ack = 1'b0;

    // Reset for two edges while RIGHT is held with its press flag pending.
    b = a + 24;
    wait_to(b);
    ifa.buttons_in[3] = 1'b1;
    expect_at(b + 6,  K_HELD_A, "t6_held",       32'h08);
    expect_at(b + 7,  K_CS_A,   "t6_press",      32'h100);
    expect_at(b + 11, K_CS_A,   "t6_rst_cs",     32'h0);
    expect_at(b + 11, K_HELD_A, "t6_rst_held",   32'h0);
    expect_at(b + 11, K_EP_A,   "t6_rst_pend",   32'h0);
    expect_at(b + 17, K_HELD_A, "t6_held_early", 32'h0);
    expect_at(b + 18, K_HELD_A, "t6_reheld",     32'h08);
    expect_at(b + 18, K_CS_A,   "t6_cs_early",   32'h0);
    expect_at(b + 19, K_CS_A,   "t6_repress",    32'h100);
    expect_at(b + 21, K_CS_A,   "t6_acked",      32'h0);
    expect_at(b + 29, K_CS_A,   "t6_release",    32'h008);
    wait_to(b + 10);
    reset = 1'b1;
    wait_to(b + 12);
    reset = 1'b0;
    wait_to(b + 20);
    ifa.ack = 1'b1;
    wait_to(b + 21);
    ifa.ack = 1'b0;
    wait_to(b + 22);
    ifa.buttons_in[3] = 1'b0;
    wait_to(b + 30);
    ifa.ack = 1'b1;
    wait_to(b + 31);
    ifa.ack = 1'b0;

    // Auto-repeat on the second unit, acked every cycle.
    p = b + 34;
    wait_to(p);
    ifb.buttons_in[0] = 1'b1;
    expect_at(p + 5,  K_HELD_B, "t5_held_early", 32'h0);
    expect_at(p + 6,  K_HELD_B, "t5_held",       32'h01);
    expect_at(p + 33, K_HELD_B, "t5_held_late",  32'h01);
    expect_at(p + 34, K_HELD_B, "t5_released",   32'h0);
    for (int c = p + 1; c <= p + 40; c++) begin
      expect_at(c, K_CS_B, $sformatf("t5_cs_e%0d", c - p), rep_expect(c, p));
    end
    wait_to(p + 28);
    ifb.buttons_in[0] = 1'b0;

    wait_to(p + 45);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
